// File: rtl/gau_pkg.sv
// gau_pkg: shared constants for the gate array unit (op encoding, default
// lane geometry and output buffer depth).
package gau_pkg;

    localparam int GAU_LANE_W     = 4;
    localparam int GAU_LANES      = 4;
    localparam int GAU_FIFO_DEPTH = 2;

    // Operation select carried on in_op; OP_ACC folds beats into an accumulator
    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_XOR = 2'd2,
        OP_ACC = 2'd3
    } gau_op_e;

endpackage

// File: rtl/gau_lane.sv
// gau_lane: one lane of the gate array. Applies the selected bitwise op to
// LANE_W bits and flags an all-zero lane result. Purely combinational.
module gau_lane
    import gau_pkg::*;
#(
    parameter int LANE_W = GAU_LANE_W
) (
    input  logic [1:0]        op,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic [LANE_W-1:0] acc,
    output logic [LANE_W-1:0] res,
    output logic              zero
);

    // Select the lane result; ACC folds both operands into the running value
    always_comb begin
        res = '0;
        case (gau_op_e'(op))
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_ACC:  res = acc & a & b;
            default: res = '0;
        endcase
    end

    assign zero = ~|res;

endmodule

// File: rtl/gate_array_unit.sv
// gate_array_unit: registered, handshaked bitwise op across LANES lanes of
// LANE_W bits, with a multi-beat accumulated AND and a 2-entry output FIFO.
// Optional feature: define GATE_ARRAY_UNIT_PARITY_EN to add out_par, the
// per-lane even parity of each result, stored alongside the data.
module gate_array_unit
    import gau_pkg::*;
#(
    parameter int LANE_W = GAU_LANE_W,
    parameter int LANES  = GAU_LANES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic                     in_last,
    input  logic [LANE_W*LANES-1:0]  in_a,
    input  logic [LANE_W*LANES-1:0]  in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANE_W*LANES-1:0]  out_data,
    output logic [LANES-1:0]         out_zero
`ifdef GATE_ARRAY_UNIT_PARITY_EN
    ,
    output logic [LANES-1:0]         out_par
`endif
);

    localparam int DW = LANE_W * LANES;
    localparam logic [1:0] DEPTH = 2'(GAU_FIFO_DEPTH);

    logic [DW-1:0]    acc;
    logic [DW-1:0]    lane_res;
    logic [LANES-1:0] lane_zero;

    logic [DW-1:0]    mem_data [GAU_FIFO_DEPTH];
    logic [LANES-1:0] mem_zero [GAU_FIFO_DEPTH];
    logic [0:0]       wr_ptr;
    logic [0:0]       rd_ptr;
    logic [1:0]       count;

    logic accept;
    logic is_acc;
    logic push;
    logic pop;

    // Lane array: the flat operand and accumulator buses split LANE_W bits per instance
    gau_lane #(.LANE_W(LANE_W)) u_lane [LANES-1:0] (
        .op   (in_op),
        .a    (in_a),
        .b    (in_b),
        .acc  (acc),
        .res  (lane_res),
        .zero (lane_zero)
    );

    // in_ready depends only on the registered count, never on out_ready
    assign in_ready  = (count < DEPTH);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign is_acc    = (gau_op_e'(in_op) == OP_ACC);
    assign push      = accept && (!is_acc || in_last);
    assign pop       = out_valid && out_ready;

    assign out_data  = mem_data[rd_ptr];
    assign out_zero  = mem_zero[rd_ptr];

    // Accumulator: non-last ACC beats fold in, the last beat restarts it at all ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '1;
        end else if (accept && is_acc) begin
            acc <= in_last ? '1 : lane_res;
        end
    end

    // Output FIFO: write at wr_ptr, read at rd_ptr, occupancy tracked in count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < GAU_FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_zero[i] <= '1;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= lane_res;
                mem_zero[wr_ptr] <= lane_zero;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef GATE_ARRAY_UNIT_PARITY_EN
    logic [LANES-1:0] lane_par;
    logic [LANES-1:0] mem_par [GAU_FIFO_DEPTH];

    // Even parity of each lane result, computed before it enters the FIFO
    always_comb begin
        lane_par = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_par[i] = ^lane_res[i*LANE_W +: LANE_W];
        end
    end

    // Parity storage follows the same write pointer as the data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < GAU_FIFO_DEPTH; i++) begin
                mem_par[i] <= '0;
            end
        end else if (push) begin
            mem_par[wr_ptr] <= lane_par;
        end
    end

    assign out_par = mem_par[rd_ptr];
`endif

endmodule

// File: tb/tb_gate_array_unit.sv
// tb_gate_array_unit: directed scenarios on the default 4x4 unit plus a
// randomized run on an 8x3 unit checked against a queue-based model.
module tb_gate_array_unit;
    import gau_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    // Default geometry instance (16-bit)
    logic        in_valid0 = 1'b0, in_ready0, in_last0 = 1'b0;
    logic [1:0]  in_op0 = 2'd0;
    logic [15:0] in_a0 = '0, in_b0 = '0, out_data0;
    logic        out_valid0, out_ready0 = 1'b0;
    logic [3:0]  out_zero0;

    // Random-run instance (LANE_W=8, LANES=3)
    logic        in_valid1 = 1'b0, in_ready1, in_last1 = 1'b0;
    logic [1:0]  in_op1 = 2'd0;
    logic [23:0] in_a1 = '0, in_b1 = '0, out_data1;
    logic        out_valid1, out_ready1 = 1'b0;
    logic [2:0]  out_zero1;

`ifdef GATE_ARRAY_UNIT_PARITY_EN
    logic [3:0]  out_par0;
    logic [2:0]  out_par1;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    gate_array_unit u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_op(in_op0), .in_last(in_last0),
        .in_a(in_a0), .in_b(in_b0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_zero(out_zero0)
`ifdef GATE_ARRAY_UNIT_PARITY_EN
        , .out_par(out_par0)
`endif
    );

    gate_array_unit #(.LANE_W(8), .LANES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_op(in_op1), .in_last(in_last1),
        .in_a(in_a1), .in_b(in_b1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_zero(out_zero1)
`ifdef GATE_ARRAY_UNIT_PARITY_EN
        , .out_par(out_par1)
`endif
    );

    typedef struct packed {
        logic [23:0] data;
        logic [2:0]  zero;
        logic [2:0]  par;
    } exp_t;

    // Drive one beat (or idle) onto the default instance
    task automatic applyStimulus(input logic v, input logic [1:0] op, input logic last,
                                 input logic [15:0] a, input logic [15:0] b);
        in_valid0 = v;
        in_op0    = op;
        in_last0  = last;
        in_a0     = a;
        in_b0     = b;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (out_valid0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %0b want 0", out_valid0); end
        tests_run++; if (in_ready0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready0); end
        tests_run++; if (out_data0 !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_out_data: got %h want 0000", out_data0); end
        tests_run++; if (out_zero0 !== 4'hF) begin tests_failed++; $display("[TB] FAIL reset_out_zero: got %b want 1111", out_zero0); end
        tests_run++; if (out_zero1 !== 3'b111) begin tests_failed++; $display("[TB] FAIL reset_out_zero_8x3: got %b want 111", out_zero1); end
`ifdef GATE_ARRAY_UNIT_PARITY_EN
        tests_run++; if (out_par0 !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_out_par: got %b want 0000", out_par0); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_and();
        out_ready0 = 1'b1;
        @(negedge clk); applyStimulus(1'b1, OP_AND, 1'b0, 16'h00FF, 16'h0F0F);
        @(negedge clk); applyStimulus(1'b0, OP_AND, 1'b0, 16'h0000, 16'h0000);
        tests_run++; if (out_valid0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL and_valid: got %0b want 1", out_valid0); end
        tests_run++; if (out_data0 !== 16'h000F) begin tests_failed++; $display("[TB] FAIL and_data: got %h want 000f", out_data0); end
        tests_run++; if (out_zero0 !== 4'b1110) begin tests_failed++; $display("[TB] FAIL and_zero: got %b want 1110", out_zero0); end
        @(negedge clk);
        tests_run++; if (out_valid0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL and_drained: got %0b want 0", out_valid0); end
    endtask

    task automatic test_back_to_back();
        out_ready0 = 1'b1;
        @(negedge clk); applyStimulus(1'b1, OP_XOR, 1'b0, 16'hFFFF, 16'h1234);
        @(negedge clk); applyStimulus(1'b1, OP_OR, 1'b0, 16'h1000, 16'h0001);
        tests_run++; if (out_data0 !== 16'hEDCB || out_valid0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_xor: got %h/%0b want edcb/1", out_data0, out_valid0); end
        tests_run++; if (in_ready0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_ready: got %0b want 1", in_ready0); end
        @(negedge clk); applyStimulus(1'b0, OP_AND, 1'b0, 16'h0000, 16'h0000);
        tests_run++; if (out_data0 !== 16'h1001 || out_valid0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_or: got %h/%0b want 1001/1", out_data0, out_valid0); end
        tests_run++; if (out_zero0 !== 4'b0110) begin tests_failed++; $display("[TB] FAIL b2b_or_zero: got %b want 0110", out_zero0); end
        @(negedge clk);
        tests_run++; if (out_valid0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_drained: got %0b want 0", out_valid0); end
    endtask

    task automatic test_acc();
        out_ready0 = 1'b1;
        @(negedge clk); applyStimulus(1'b1, OP_ACC, 1'b0, 16'hFFF0, 16'hFFFF);
        @(negedge clk); applyStimulus(1'b1, OP_ACC, 1'b0, 16'hFF0F, 16'hFFFF);
        tests_run++; if (out_valid0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL acc_beat1_silent: got %0b want 0", out_valid0); end
        @(negedge clk); applyStimulus(1'b1, OP_ACC, 1'b1, 16'h0FFF, 16'hFFFF);
        tests_run++; if (out_valid0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL acc_beat2_silent: got %0b want 0", out_valid0); end
        @(negedge clk); applyStimulus(1'b0, OP_AND, 1'b0, 16'h0000, 16'h0000);
        tests_run++; if (out_data0 !== 16'h0F00 || out_valid0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL acc_result: got %h/%0b want 0f00/1", out_data0, out_valid0); end
        tests_run++; if (out_zero0 !== 4'b1011) begin tests_failed++; $display("[TB] FAIL acc_zero: got %b want 1011", out_zero0); end
        @(negedge clk);
        tests_run++; if (out_valid0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL acc_single: got %0b want 0", out_valid0); end
    endtask

    task automatic test_back_pressure();
        out_ready0 = 1'b0;
        @(negedge clk); applyStimulus(1'b1, OP_OR, 1'b0, 16'h1111, 16'h0000);
        tests_run++; if (in_ready0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_ready_empty: got %0b want 1", in_ready0); end
        @(negedge clk); applyStimulus(1'b1, OP_OR, 1'b0, 16'h2222, 16'h0000);
        tests_run++; if (in_ready0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_ready_one: got %0b want 1", in_ready0); end
        @(negedge clk); applyStimulus(1'b1, OP_OR, 1'b0, 16'h3333, 16'h0000);
        tests_run++; if (in_ready0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_ready_full: got %0b want 0", in_ready0); end
        @(negedge clk);
        tests_run++; if (in_ready0 !== 1'b0 || out_data0 !== 16'h1111) begin tests_failed++; $display("[TB] FAIL bp_hold: got %0b/%h want 0/1111", in_ready0, out_data0); end
        @(negedge clk); out_ready0 = 1'b1;
        tests_run++; if (out_data0 !== 16'h1111 || out_valid0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_stable: got %h/%0b want 1111/1", out_data0, out_valid0); end
        @(negedge clk);
        tests_run++; if (out_data0 !== 16'h2222 || in_ready0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_second: got %h/%0b want 2222/1", out_data0, in_ready0); end
        @(negedge clk); applyStimulus(1'b0, OP_AND, 1'b0, 16'h0000, 16'h0000);
        tests_run++; if (out_data0 !== 16'h3333 || out_valid0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_third: got %h/%0b want 3333/1", out_data0, out_valid0); end
        @(negedge clk);
        tests_run++; if (out_valid0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_drained: got %0b want 0", out_valid0); end
    endtask

    task automatic test_reset_mid();
        out_ready0 = 1'b0;
        @(negedge clk); applyStimulus(1'b1, OP_ACC, 1'b0, 16'hFFF0, 16'hFFFF);
        @(negedge clk); applyStimulus(1'b1, OP_AND, 1'b0, 16'hFFFF, 16'h1234);
        @(negedge clk); applyStimulus(1'b1, OP_AND, 1'b0, 16'hFFFF, 16'h5678);
        @(negedge clk); applyStimulus(1'b0, OP_AND, 1'b0, 16'h0000, 16'h0000);
        tests_run++; if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL rmid_full: got %0b/%0b want 0/1", in_ready0, out_valid0); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (out_valid0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rmid_valid: got %0b want 0", out_valid0); end
        tests_run++; if (in_ready0 !== 1'b1 || out_data0 !== 16'h0000 || out_zero0 !== 4'hF) begin tests_failed++; $display("[TB] FAIL rmid_outputs: got %0b/%h/%b want 1/0000/1111", in_ready0, out_data0, out_zero0); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); out_ready0 = 1'b1; applyStimulus(1'b1, OP_ACC, 1'b1, 16'hFFFF, 16'hFFFF);
        @(negedge clk); applyStimulus(1'b0, OP_AND, 1'b0, 16'h0000, 16'h0000);
        tests_run++; if (out_data0 !== 16'hFFFF || out_valid0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL rmid_fresh_acc: got %h/%0b want ffff/1", out_data0, out_valid0); end
        tests_run++; if (out_zero0 !== 4'h0) begin tests_failed++; $display("[TB] FAIL rmid_fresh_zero: got %b want 0000", out_zero0); end
        @(negedge clk);
        tests_run++; if (out_valid0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rmid_drained: got %0b want 0", out_valid0); end
    endtask

    // Reference entry for an 8x3 result word: per-lane zero flag and parity
    function automatic exp_t make_entry(input logic [23:0] r);
        exp_t e;
        e.data = r;
        for (int i = 0; i < 3; i++) begin
            e.zero[i] = (r[i*8 +: 8] == 8'h00);
            e.par[i]  = ^r[i*8 +: 8];
        end
        return e;
    endfunction

    task automatic test_random();
        exp_t        q[$];
        exp_t        head;
        logic [23:0] acc_m = '1;
        logic [23:0] r;
        int          accepted = 0;
        int          cycles = 0;
        while (accepted < 2000 && cycles < 20000) begin
            @(negedge clk);
            tests_run++; if (out_valid1 !== (q.size() != 0)) begin tests_failed++; $display("[TB] FAIL rand_valid cyc %0d: got %0b want %0b", cycles, out_valid1, q.size() != 0); end
            tests_run++; if (in_ready1 !== (q.size() < 2)) begin tests_failed++; $display("[TB] FAIL rand_ready cyc %0d: got %0b want %0b", cycles, in_ready1, q.size() < 2); end
            if (q.size() != 0) begin
                head = q[0];
                tests_run++; if (out_data1 !== head.data) begin tests_failed++; $display("[TB] FAIL rand_data cyc %0d: got %h want %h", cycles, out_data1, head.data); end
                tests_run++; if (out_zero1 !== head.zero) begin tests_failed++; $display("[TB] FAIL rand_zero cyc %0d: got %b want %b", cycles, out_zero1, head.zero); end
`ifdef GATE_ARRAY_UNIT_PARITY_EN
                tests_run++; if (out_par1 !== head.par) begin tests_failed++; $display("[TB] FAIL rand_par cyc %0d: got %b want %b", cycles, out_par1, head.par); end
`endif
            end
            in_valid1  = ($urandom_range(0, 99) < 70);
            in_op1     = 2'($urandom_range(0, 3));
            in_last1   = ($urandom_range(0, 2) == 0);
            in_a1      = (in_op1 == OP_ACC) ? 24'($urandom | $urandom) : 24'($urandom);
            in_b1      = (in_op1 == OP_ACC) ? 24'($urandom | $urandom) : 24'($urandom);
            if ($urandom_range(0, 3) == 0) in_a1[8*$urandom_range(0, 2) +: 8] = 8'h00;
            out_ready1 = ($urandom_range(0, 99) < 60);
            if (q.size() != 0 && out_ready1) void'(q.pop_front());
            if (in_valid1 && (q.size() + ((q.size() != 0 && out_ready1) ? 1 : 0)) < 2) begin
                accepted++;
                case (in_op1)
                    2'd0: r = in_a1 & in_b1;
                    2'd1: r = in_a1 | in_b1;
                    2'd2: r = in_a1 ^ in_b1;
                    default: r = acc_m & in_a1 & in_b1;
                endcase
                if (in_op1 != 2'd3) q.push_back(make_entry(r));
                else if (in_last1) begin q.push_back(make_entry(r)); acc_m = '1; end
                else acc_m = r;
            end
            cycles++;
        end
        tests_run++; if (accepted < 2000) begin tests_failed++; $display("[TB] FAIL rand_timeout: got %0d beats want 2000", accepted); end
        @(negedge clk); in_valid1 = 1'b0; out_ready1 = 1'b1;
    endtask

    // Hard stop in case a handshake never completes
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Run every scenario in order and report
    initial begin
        test_reset();
        test_and();
        test_back_to_back();
        test_acc();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
